// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle from vga_timing to gameplay.
// Master drives the counters and decodes, slave samples them.
interface vga_timing_if;
    logic [15:0] H;
    logic [15:0] V;
    logic        active_region;
    logic        refresh;
    logic        Hsync;
    logic        Vsync;
    logic        pix_en;
    logic [15:0] frame_count;

    modport master (
        output H, V, active_region, refresh,
        output Hsync, Vsync, pix_en, frame_count
    );

    modport slave (
        input H, V, active_region, refresh,
        input Hsync, Vsync, pix_en, frame_count
    );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: pixel-rate divider, H/V raster counters and registered
// sync/active/refresh decodes feeding gameplay.
module vga_timing #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic         clkin,
    input  logic         resetn,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DW-1:0] divCnt;
    logic          tick;
    logic          hEnd;
    logic          vEnd;
    logic [15:0]   hCnt;
    logic [15:0]   vCnt;
    logic [15:0]   hNext;
    logic [15:0]   vNext;
    logic [15:0]   frameCnt;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          refresh;
    logic          pixEn;
    logic          activeNext;
    logic          hsyncNext;
    logic          vsyncNext;
    logic          refreshNext;

    assign tick = (divCnt == DW'(PIX_DIV - 1));
    assign hEnd = (hCnt == 16'(H_TOTAL - 1));
    assign vEnd = (vCnt == 16'(V_TOTAL - 1));

    always_comb begin
        hNext = hCnt;
        vNext = vCnt;
        unique case (1'b1)
            !tick: ;
            tick && !hEnd: begin
                hNext = hCnt + 16'd1;
            end
            tick && hEnd && !vEnd: begin
                hNext = 16'd0;
                vNext = vCnt + 16'd1;
            end
            tick && hEnd && vEnd: begin
                hNext = 16'd0;
                vNext = 16'd0;
            end
            default: ;
        endcase
    end

    // Decodes look at the next position so they land with the counters.
    always_comb begin
        activeNext  = (hNext < 16'(H_ACTIVE))
                   && (vNext < 16'(V_ACTIVE));
        hsyncNext   = !((hNext >= 16'(HS_LO))
                   && (hNext < 16'(HS_HI)));
        vsyncNext   = !((vNext >= 16'(VS_LO))
                   && (vNext < 16'(VS_HI)));
        refreshNext = tick && (hNext == 16'd0)
                   && (vNext == 16'(V_ACTIVE));
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            divCnt   <= '0;
            pixEn    <= 1'b0;
            hCnt     <= 16'd0;
            vCnt     <= 16'd0;
            active   <= 1'b0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            refresh  <= 1'b0;
            frameCnt <= 16'd0;
        end else begin
            divCnt  <= tick ? '0 : divCnt + DW'(1);
            pixEn   <= tick;
            refresh <= refreshNext;
            if (refreshNext) begin
                frameCnt <= frameCnt + 16'd1;
            end
            if (tick) begin
                hCnt   <= hNext;
                vCnt   <= vNext;
                active <= activeNext;
                hsync  <= hsyncNext;
                vsync  <= vsyncNext;
            end
        end
    end

    assign vga.H             = hCnt;
    assign vga.V             = vCnt;
    assign vga.active_region = active;
    assign vga.refresh       = refresh;
    assign vga.Hsync         = hsync;
    assign vga.Vsync         = vsync;
    assign vga.pix_en        = pixEn;
    assign vga.frame_count   = frameCnt;
endmodule
